// File: rtl/pito_irq_router.sv
// pito_irq_router: routes interrupt events from NUM_SRC sources into per-hart FIFOs.
// Ports: src_valid_i/src_hart_i/src_data_i/src_ready_o = source handshake (one grant per cycle);
//        irq_en_i/irq_o/irq_data_o/irq_src_o/irq_ack_i = per-hart queue head and pop;
//        fifo_full_o = per-hart full flag; drop_cnt_o = saturating discarded-event count.
// Optional feature: define PITO_IRQ_BCAST_EN to push broadcast events into every hart queue;
// without it, broadcast events are accepted and counted as drops.
// Latency: irq_o rises one cycle after the transfer. src_ready_o is combinational.
module pito_irq_router #(
   parameter int NUM_HARTS  = 8,
   parameter int NUM_SRC    = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_SRC-1:0]                     src_valid_i,
   input  logic [NUM_SRC*($clog2(NUM_HARTS)+1)-1:0] src_hart_i,
   input  logic [NUM_SRC*DATA_W-1:0]              src_data_i,
   output logic [NUM_SRC-1:0]                     src_ready_o,
   input  logic [NUM_HARTS-1:0]                   irq_en_i,
   output logic [NUM_HARTS-1:0]                   irq_o,
   output logic [NUM_HARTS*DATA_W-1:0]            irq_data_o,
   output logic [NUM_HARTS*$clog2(NUM_SRC)-1:0]   irq_src_o,
   input  logic [NUM_HARTS-1:0]                   irq_ack_i,
   output logic [NUM_HARTS-1:0]                   fifo_full_o,
   output logic [15:0]                            drop_cnt_o
);
   localparam int HW = $clog2(NUM_HARTS);
   localparam int SW = $clog2(NUM_SRC);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = DATA_W + SW;
   localparam logic [HW:0]   HART_LIM = (HW+1)'(NUM_HARTS);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [EW-1:0]        mem [NUM_HARTS][FIFO_DEPTH];
   logic [PW-1:0]        rd_ptr [NUM_HARTS];
   logic [PW-1:0]        wr_ptr [NUM_HARTS];
   logic [CW-1:0]        count [NUM_HARTS];
   logic [NUM_HARTS-1:0] full, nonempty, push, pop;
   logic [HW:0]          tgt [NUM_SRC];
   logic [NUM_SRC-1:0]   elig;
   logic                 gnt_any, gnt_drop;
   logic [SW-1:0]        gnt_idx, rr_ptr;
   logic [HW:0]          gnt_hart;
   logic [DATA_W-1:0]    gnt_data;
   logic [15:0]          drop_cnt;

   // Source index k steps after p, modulo NUM_SRC (NUM_SRC need not be a power of two).
   function automatic logic [SW-1:0] rr_next(input logic [SW-1:0] p, input int k);
      return SW'((int'(p) + k) % NUM_SRC);
   endfunction

   always_comb begin
      full     = '0;
      nonempty = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         full[h]     = (count[h] == FULL_CNT);
         nonempty[h] = (count[h] != '0);
      end
   end

   // Eligibility uses registered occupancy only: a same-cycle pop never frees a slot early.
   always_comb begin
      elig = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         tgt[s] = src_hart_i[s*(HW+1) +: HW+1];
         if (tgt[s][HW]) begin
`ifdef PITO_IRQ_BCAST_EN
            elig[s] = src_valid_i[s] & ~(|full);
`else
            elig[s] = src_valid_i[s];
`endif
         end else if (tgt[s] >= HART_LIM) begin
            elig[s] = src_valid_i[s];
         end else begin
            elig[s] = src_valid_i[s] & ~full[tgt[s][HW-1:0]];
         end
      end
   end

   // Round-robin search starting one past the last granted source; no grant while in reset.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         if (!gnt_any && elig[rr_next(rr_ptr, k)]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_next(rr_ptr, k);
         end
      end
      if (rst) gnt_any = 1'b0;
      src_ready_o = gnt_any ? (NUM_SRC'(1) << gnt_idx) : '0;
      gnt_hart    = tgt[gnt_idx];
      gnt_data    = src_data_i[gnt_idx*DATA_W +: DATA_W];
   end

   always_comb begin
      push     = '0;
      gnt_drop = 1'b0;
      if (gnt_any) begin
         if (gnt_hart[HW]) begin
`ifdef PITO_IRQ_BCAST_EN
            push = '1;
`else
            gnt_drop = 1'b1;
`endif
         end else if (gnt_hart >= HART_LIM) begin
            gnt_drop = 1'b1;
         end else begin
            push[gnt_hart[HW-1:0]] = 1'b1;
         end
      end
      pop = irq_ack_i & nonempty;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= SW'(NUM_SRC - 1);
         drop_cnt <= '0;
         for (int h = 0; h < NUM_HARTS; h++) begin
            rd_ptr[h] <= '0;
            wr_ptr[h] <= '0;
            count[h]  <= '0;
         end
      end else begin
         if (gnt_any) rr_ptr <= gnt_idx;
         if (gnt_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (push[h]) wr_ptr[h] <= wr_ptr[h] + 1'b1;
            if (pop[h])  rd_ptr[h] <= rd_ptr[h] + 1'b1;
            case ({push[h], pop[h]})
               2'b10:   count[h] <= count[h] + CW'(1);
               2'b01:   count[h] <= count[h] - CW'(1);
               default: count[h] <= count[h];
            endcase
         end
      end
   end

   // Storage is not reset; outputs are masked to zero while a queue is empty.
   always_ff @(posedge clk) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (push[h]) mem[h][wr_ptr[h]] <= {gnt_data, gnt_idx};
      end
   end

   always_comb begin
      irq_o       = '0;
      fifo_full_o = '0;
      irq_data_o  = '0;
      irq_src_o   = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         irq_o[h]       = nonempty[h] & irq_en_i[h];
         fifo_full_o[h] = full[h];
         if (nonempty[h])
            {irq_data_o[h*DATA_W +: DATA_W], irq_src_o[h*SW +: SW]} = mem[h][rd_ptr[h]];
      end
   end

   assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_pito_irq_router.sv
// Testbench for pito_irq_router: directed scenarios plus randomized traffic checked
// against a queue-based reference model; a second instance with 6 harts covers
// out-of-range targets.
module tb_pito_irq_router;
   localparam int NH = 8;
   localparam int NS = 4;
   localparam int DW = 32;
   localparam int FD = 4;
   localparam int HW = 3;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [NS-1:0]        src_valid = '0;
   logic [NS*(HW+1)-1:0] src_hart  = '0;
   logic [NS*DW-1:0]     src_data  = '0;
   logic [NS-1:0]        src_ready;
   logic [NH-1:0]        irq_en    = '1;
   logic [NH-1:0]        irq_ack   = '0;
   logic [NH-1:0]        irq, fifo_full;
   logic [NH*DW-1:0]     irq_data;
   logic [NH*SW-1:0]     irq_src;
   logic [15:0]          drop_cnt;

   pito_irq_router u_dut (
      .clk(clk), .rst(rst),
      .src_valid_i(src_valid), .src_hart_i(src_hart), .src_data_i(src_data),
      .src_ready_o(src_ready),
      .irq_en_i(irq_en), .irq_o(irq), .irq_data_o(irq_data), .irq_src_o(irq_src),
      .irq_ack_i(irq_ack), .fifo_full_o(fifo_full), .drop_cnt_o(drop_cnt)
   );

   // Six-hart instance: hart index 7 is out of range.
   logic [NS-1:0]     src_valid6 = '0;
   logic [NS*4-1:0]   src_hart6  = '0;
   logic [NS*DW-1:0]  src_data6  = '0;
   logic [NS-1:0]     src_ready6;
   logic [5:0]        irq_en6 = '1, irq_ack6 = '0, irq6, fifo_full6;
   logic [6*DW-1:0]   irq_data6;
   logic [6*SW-1:0]   irq_src6;
   logic [15:0]       drop6;

   pito_irq_router #(.NUM_HARTS(6)) u_dut6 (
      .clk(clk), .rst(rst),
      .src_valid_i(src_valid6), .src_hart_i(src_hart6), .src_data_i(src_data6),
      .src_ready_o(src_ready6),
      .irq_en_i(irq_en6), .irq_o(irq6), .irq_data_o(irq_data6), .irq_src_o(irq_src6),
      .irq_ack_i(irq_ack6), .fifo_full_o(fifo_full6), .drop_cnt_o(drop6)
   );

   // Reference model: one queue of {data, source} per hart, last granted source, drop count.
   logic [DW+SW-1:0] mq [NH][$];
   int last  = NS - 1;
   int mdrop = 0;
   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit eligible(input int s);
      logic [3:0] hv;
      hv = src_hart[s*4 +: 4];
      if (hv[3]) begin
`ifdef PITO_IRQ_BCAST_EN
         for (int h = 0; h < NH; h++) if (mq[h].size() >= FD) return 1'b0;
         return 1'b1;
`else
         return 1'b1;
`endif
      end
      return mq[hv[2:0]].size() < FD;
   endfunction

   // One clock: predict and check outputs for the current inputs, then advance the model.
   task automatic step();
      int g;
      logic [NS-1:0]    er;
      logic [NH-1:0]    ei, ef;
      logic [NH*DW-1:0] ed;
      logic [NH*SW-1:0] es;
      logic [3:0]       hv;
      logic [DW-1:0]    d;
      #1;
      g = -1;
      for (int k = 1; k <= NS; k++) begin
         int s;
         s = (last + k) % NS;
         if (g < 0 && src_valid[s] && eligible(s)) g = s;
      end
      er = '0; ei = '0; ef = '0; ed = '0; es = '0;
      if (g >= 0) er[g] = 1'b1;
      for (int h = 0; h < NH; h++) begin
         ef[h] = (mq[h].size() == FD);
         if (mq[h].size() > 0) begin
            ei[h] = irq_en[h];
            ed[h*DW +: DW] = mq[h][0][DW+SW-1:SW];
            es[h*SW +: SW] = mq[h][0][SW-1:0];
         end
      end
      chk("src_ready", src_ready, er);
      chk("irq", irq, ei);
      chk("fifo_full", fifo_full, ef);
      chk("irq_data", irq_data, ed);
      chk("irq_src", irq_src, es);
      chk("drop_cnt", drop_cnt, mdrop);
      @(posedge clk);
      for (int h = 0; h < NH; h++)
         if (irq_ack[h] && mq[h].size() > 0) void'(mq[h].pop_front());
      if (g >= 0) begin
         hv = src_hart[g*4 +: 4];
         d  = src_data[g*DW +: DW];
         if (hv[3]) begin
`ifdef PITO_IRQ_BCAST_EN
            for (int h = 0; h < NH; h++) mq[h].push_back({d, 2'(g)});
`else
            if (mdrop < 65535) mdrop++;
`endif
         end else begin
            mq[hv[2:0]].push_back({d, 2'(g)});
         end
         last = g;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      src_valid = '1;
      #1;
      chk("rst_ready", src_ready, 0);
      chk("rst_irq", irq, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_data", irq_data, 0);
      chk("rst_src", irq_src, 0);
      chk("rst_drop", drop_cnt, 0);
      for (int h = 0; h < NH; h++) mq[h].delete();
      last = NS - 1;
      mdrop = 0;
      @(posedge clk);
      #1;
      src_valid = '0;
      rst = 1'b0;
   endtask

   logic [NS-1:0] rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   initial begin
      // Reset state
      do_reset();

      // Single event to hart 2
      src_valid = 4'b0001; src_hart[3:0] = 4'd2; src_data[31:0] = 32'hDEAD_BEEF;
      #1 chk("t1_ready", src_ready, 4'b0001);
      step();
      src_valid = '0;
      chk("t1_irq", irq, 8'h04);
      chk("t1_data2", irq_data[2*DW +: DW], 32'hDEAD_BEEF);
      chk("t1_src2", irq_src[2*SW +: SW], 0);
      irq_ack = 8'h04; step(); irq_ack = '0;

      // Round-robin rotation from a fresh reset
      do_reset();
      src_valid = 4'b1111;
      for (int s = 0; s < NS; s++) begin
         src_hart[s*4 +: 4] = 4'd1;
         src_data[s*DW +: DW] = 32'hA000 + s;
      end
      irq_ack = '1;
      for (int i = 0; i < 5; i++) begin
         #1 chk("t2_rot", src_ready, rot_exp[i]);
         step();
      end
      src_valid = '0; step(); irq_ack = '0;

      // Fill hart 5 to full, backpressure, one ack frees a slot next cycle
      src_valid = 4'b0001; src_hart[3:0] = 4'd5;
      for (int i = 0; i < FD; i++) begin
         src_data[31:0] = 32'h5500 + i;
         step();
      end
      src_data[31:0] = 32'h55FF;
      chk("t3_full5", fifo_full[5], 1'b1);
      chk("t3_blocked", src_ready, 0);
      step();
      irq_ack = 8'h20;
      chk("t3_ack_cycle", src_ready, 0);
      step();
      irq_ack = '0;
      chk("t3_accept", src_ready, 4'b0001);
      step();
      src_valid = '0;
      chk("t3_full_again", fifo_full[5], 1'b1);
      irq_ack = 8'h20;
      for (int i = 0; i < FD; i++) step();
      irq_ack = '0;

      // Disabled hart still queues; enable gates irq_o combinationally
      irq_en = 8'hF7;
      src_valid = 4'b0010; src_hart[7:4] = 4'd3; src_data[63:32] = 32'h3333_0001;
      step();
      src_valid = '0;
      #1;
      chk("t4_irq_off", irq[3], 1'b0);
      chk("t4_data3", irq_data[3*DW +: DW], 32'h3333_0001);
      chk("t4_src3", irq_src[3*SW +: SW], 2'd1);
      irq_en = 8'hFF;
      #1 chk("t4_irq_on", irq[3], 1'b1);
      irq_ack = 8'h08; step(); irq_ack = '0;

      // Broadcast event
      do_reset();
      src_valid = 4'b0001; src_hart[3:0] = 4'b1000; src_data[31:0] = 32'h1234;
      step();
      src_valid = '0;
`ifdef PITO_IRQ_BCAST_EN
      for (int h = 0; h < NH; h++) chk("t5_bcast_data", irq_data[h*DW +: DW], 32'h1234);
      chk("t5_bcast_irq", irq, 8'hFF);
`else
      chk("t5_drop", drop_cnt, 16'd1);
      chk("t5_no_irq", irq, 8'h00);
`endif
      irq_ack = '1; step(); irq_ack = '0;

      // Reset asserted mid-transfer discards everything
      src_valid = 4'b1111;
      for (int s = 0; s < NS; s++) src_hart[s*4 +: 4] = 4'(s + 2);
      step(); step();
      #2 rst = 1'b1;
      #1;
      chk("t6_ready", src_ready, 0);
      chk("t6_irq", irq, 0);
      chk("t6_full", fifo_full, 0);
      chk("t6_data", irq_data, 0);
      chk("t6_drop", drop_cnt, 0);
      @(posedge clk);
      #1;
      for (int h = 0; h < NH; h++) mq[h].delete();
      last = NS - 1;
      mdrop = 0;
      src_valid = '0;
      rst = 1'b0;
      step();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         src_valid = 4'($urandom);
         for (int s = 0; s < NS; s++) begin
            src_hart[s*4 +: 3] = 3'($urandom_range(0, 7));
            src_hart[s*4 + 3]  = ($urandom_range(0, 7) == 0);
            src_data[s*DW +: DW] = $urandom;
         end
         irq_ack = 8'($urandom & $urandom);
         irq_en  = 8'($urandom | $urandom);
         step();
      end
      src_valid = '0;
      irq_ack = '0;

      // Out-of-range target on the six-hart instance
      src_valid6 = 4'b0001; src_hart6[3:0] = 4'd7; src_data6[31:0] = 32'h7777;
      #1;
      chk("t7_ready", src_ready6, 4'b0001);
      chk("t7_drop_before", drop6, 16'd0);
      @(posedge clk);
      #1;
      src_valid6 = '0;
      chk("t7_drop_after", drop6, 16'd1);
      chk("t7_irq", irq6, 0);
      chk("t7_full", fifo_full6, 0);
      chk("t7_data", irq_data6, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pito_irq_router.md
PITO_IRQ_ROUTER -- requirements
Module: pito_irq_router

Interface
REQ-001 Parameter NUM_HARTS, default 8, number of destination harts; HW = $clog2(NUM_HARTS).
REQ-002 Parameter NUM_SRC, default 4, number of interrupt event sources; SW = $clog2(NUM_SRC).
REQ-003 Parameter DATA_W, default 32, event payload width.
REQ-004 Parameter FIFO_DEPTH, default 4, power of two, per-hart event queue depth.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 src_valid_i  in  NUM_SRC  per-source event valid.
REQ-008 src_hart_i  in  NUM_SRC*(HW+1)  per-source target; MSB = broadcast flag, low HW bits = hart index.
REQ-009 src_data_i  in  NUM_SRC*DATA_W  per-source payload.
REQ-010 src_ready_o  out  NUM_SRC  one-hot grant; event transferred when valid and ready are both high.
REQ-011 irq_en_i  in  NUM_HARTS  per-hart enable, gates irq_o only.
REQ-012 irq_o  out  NUM_HARTS  hart h has an enabled pending event.
REQ-013 irq_data_o  out  NUM_HARTS*DATA_W  head-of-queue payload per hart.
REQ-014 irq_src_o  out  NUM_HARTS*SW  head-of-queue source index per hart.
REQ-015 irq_ack_i  in  NUM_HARTS  pops head of hart h queue.
REQ-016 fifo_full_o  out  NUM_HARTS  hart h queue holds FIFO_DEPTH entries.
REQ-017 drop_cnt_o  out  16  saturating count of discarded events.

Function
REQ-018 Eligibility: source s is eligible when valid and its target queue is not full; the full condition is evaluated from registered occupancy before the same-cycle pop, with no bypass.
REQ-019 Arbitration: at most one grant per cycle, round-robin starting at last granted index + 1 mod NUM_SRC; the pointer updates only on a grant.
REQ-020 src_ready_o is combinational from the current valids and occupancy, and is never asserted for an ineligible source.
REQ-021 A granted event is written as {data, source index}; irq_o rises the cycle after the transfer (1-cycle latency), given irq_en_i.
REQ-022 irq_o[h] = queue non-empty AND irq_en_i[h]; a disabled hart still queues events; irq_data_o and irq_src_o are valid whenever the queue is non-empty, independent of enable.
REQ-023 An ack on an empty queue is ignored; an ack with a same-cycle push on a non-full queue leaves occupancy unchanged.
REQ-024 Target index >= NUM_HARTS with MSB clear: the event is eligible, granted, discarded, and drop_cnt_o increments.
REQ-025 Queue pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a DEPTH+1 range counter.
REQ-026 drop_cnt_o saturates at 16'hFFFF.

Reset
REQ-027 When rst is asserted, all queues are emptied, the round-robin pointer is set to NUM_SRC-1 (source 0 first), and drop_cnt_o is set to 0.
REQ-028 Outputs during and after reset: irq_o=0, fifo_full_o=0, src_ready_o=0, irq_data_o=0, irq_src_o=0.
REQ-029 Reset asserted mid-transfer discards all queued and in-flight events with no partial write.

Configuration
REQ-030 Macro PITO_IRQ_BCAST_EN; when defined, an event with the broadcast MSB set is eligible only if all NUM_HARTS queues are non-full, and on grant it is pushed into every queue in the same cycle.
REQ-031 Without PITO_IRQ_BCAST_EN, a broadcast event is eligible, granted, discarded, and drop_cnt_o increments.

Verification
REQ-032 Reset then src0 valid, hart=2, data=32'hDEAD_BEEF, irq_en=8'hFF -> ready0 same cycle; next cycle irq_o=8'h04, irq_data[2]=DEAD_BEEF, irq_src[2]=0.
REQ-033 Sources 0-3 valid continuously to hart 1, acks held high -> grants rotate 0,1,2,3,0 on consecutive cycles.
REQ-034 Five events to hart 5, no ack, FIFO_DEPTH=4 -> four accepted, fifo_full[5]=1, fifth source ready=0 until one ack, then accepted the next cycle.
REQ-035 Event hart=3, irq_en[3]=0 -> irq_o[3]=0 while irq_data[3] is valid; raise enable -> irq_o[3]=1 same cycle.
REQ-036 Broadcast hart=4'b1000, data=32'h1234 -> with macro: all 8 queues hold 32'h1234 next cycle; without macro: drop_cnt_o=1 and no irq_o.
REQ-037 Target hart=7 with NUM_HARTS=6 -> event accepted, drop_cnt_o 0->1, no queue changes.
